// File: rtl/fetch_sequencer.sv
// Program-counter owner for the Fetch stage: issues one bundle address per cycle
// and arbitrates branch, interrupt entry/return, halt, stall and sequential PC sources.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0001,
    parameter logic [15:0] IRQ_VECTOR = 16'h0040,
    parameter int unsigned PC_LIMIT   = 100
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_target_i,
    input  logic        irq_i,
    input  logic        eret_i,
    input  logic        halt_i,
    output logic [15:0] pc_o,
    output logic        fetch_enable_o,
    output logic        flushBack_o,
    output logic        irq_ack_o,
    output logic        irq_active_o,
    output logic [15:0] epc_o,
    output logic        fault_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STALL = 3'd2,
        S_FLUSH = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [15:0] PC_LIMIT_W = 16'(PC_LIMIT);
    localparam logic [15:0] LAST_PC    = 16'(PC_LIMIT - 1);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] epc_q, epc_d;
    logic        fe_q, fe_d;
    logic        flush_q, flush_d;
    logic        ack_q, ack_d;
    logic        active_q, active_d;
    logic        fault_q, fault_d;

    logic        redirect;
    logic        take_irq;
    logic        take_eret;
    logic [15:0] target;
    logic [15:0] pc_inc;

    assign pc_inc = (pc_q >= LAST_PC) ? '0 : pc_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        fe_d      = fe_q;
        flush_d   = 1'b0;
        ack_d     = 1'b0;
        active_d  = active_q;
        fault_d   = fault_q;
        redirect  = 1'b0;
        take_irq  = 1'b0;
        take_eret = 1'b0;
        target    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    fe_d    = 1'b1;
                    pc_d    = RESET_PC;
                end
            end
            S_RUN, S_STALL, S_FLUSH: begin
                if (branch_taken_i) begin
                    redirect = 1'b1;
                    target   = branch_target_i;
                end else if (eret_i && active_q) begin
                    redirect  = 1'b1;
                    take_eret = 1'b1;
                    target    = epc_q;
                end else if (irq_i && !active_q) begin
                    redirect = 1'b1;
                    take_irq = 1'b1;
                    target   = IRQ_VECTOR;
                end else if (state_q == S_FLUSH) begin
                    // halt is deferred out of FLUSH; the redirect target is presented next
                    state_d = stall_i ? S_STALL : S_RUN;
                    fe_d    = !stall_i;
                end else if (halt_i) begin
                    state_d = S_HALT;
                    fe_d    = 1'b0;
                end else if (stall_i) begin
                    state_d = S_STALL;
                    fe_d    = 1'b0;
                end else if (state_q == S_STALL) begin
                    state_d = S_RUN;
                    fe_d    = 1'b1;
                end else begin
                    pc_d = pc_inc;
                end
            end
            S_HALT: begin
                if (irq_i && !active_q) begin
                    redirect = 1'b1;
                    take_irq = 1'b1;
                    target   = IRQ_VECTOR;
                end
            end
            default: begin
                state_d = S_IDLE;
                fe_d    = 1'b0;
            end
        endcase

        if (redirect) begin
            flush_d = 1'b1;
            fe_d    = 1'b0;
            if (target >= PC_LIMIT_W) begin
                // Illegal target: squash and park without touching pc or irq state
                fault_d = 1'b1;
                state_d = S_HALT;
            end else begin
                state_d = S_FLUSH;
                pc_d    = target;
                if (take_irq) begin
                    epc_d    = pc_q;
                    ack_d    = 1'b1;
                    active_d = 1'b1;
                end
                if (take_eret) begin
                    active_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            epc_q    <= '0;
            fe_q     <= 1'b0;
            flush_q  <= 1'b0;
            ack_q    <= 1'b0;
            active_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            fe_q     <= fe_d;
            flush_q  <= flush_d;
            ack_q    <= ack_d;
            active_q <= active_d;
            fault_q  <= fault_d;
        end
    end

    assign pc_o           = pc_q;
    assign fetch_enable_o = fe_q;
    assign flushBack_o    = flush_q;
    assign irq_ack_o      = ack_q;
    assign irq_active_o   = active_q;
    assign epc_o          = epc_q;
    assign fault_o        = fault_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a behavioural PC-source model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_sequencer;

    localparam logic [15:0] RST_PC = 16'h0001;
    localparam logic [15:0] IRQV   = 16'h0040;
    localparam int          LIMIT  = 100;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [15:0] branch_target_i = '0;
    logic        irq_i = 1'b0;
    logic        eret_i = 1'b0;
    logic        halt_i = 1'b0;
    logic [15:0] pc_o;
    logic        fetch_enable_o;
    logic        flushBack_o;
    logic        irq_ack_o;
    logic        irq_active_o;
    logic [15:0] epc_o;
    logic        fault_o;
    logic [2:0]  state_o;

    fetch_sequencer #(
        .RESET_PC  (RST_PC),
        .IRQ_VECTOR(IRQV),
        .PC_LIMIT  (LIMIT)
    ) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .irq_i          (irq_i),
        .eret_i         (eret_i),
        .halt_i         (halt_i),
        .pc_o           (pc_o),
        .fetch_enable_o (fetch_enable_o),
        .flushBack_o    (flushBack_o),
        .irq_ack_o      (irq_ack_o),
        .irq_active_o   (irq_active_o),
        .epc_o          (epc_o),
        .fault_o        (fault_o),
        .state_o        (state_o)
    );

    always #5 clock_i = ~clock_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: tracks what the fetch front-end is doing in plain terms
    int m_pc = RST_PC, m_epc = 0;
    bit m_fe = 0, m_fl = 0, m_ack = 0, m_act = 0, m_fault = 0;
    bit m_idle = 1, m_halt = 0;
    bit go, is_irq, is_eret;
    int tgt;

    always @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            m_pc = RST_PC; m_epc = 0; m_fe = 0; m_fl = 0; m_ack = 0;
            m_act = 0; m_fault = 0; m_idle = 1; m_halt = 0;
        end else if (m_idle) begin
            if (start_i) begin
                m_idle = 0; m_fe = 1; m_pc = RST_PC;
            end
        end else begin
            m_ack = 0;
            go = 0; is_irq = 0; is_eret = 0; tgt = 0;
            if (m_halt) begin
                if (irq_i && !m_act) begin go = 1; is_irq = 1; tgt = IRQV; end
            end else if (branch_taken_i) begin
                go = 1; tgt = branch_target_i;
            end else if (eret_i && m_act) begin
                go = 1; is_eret = 1; tgt = m_epc;
            end else if (irq_i && !m_act) begin
                go = 1; is_irq = 1; tgt = IRQV;
            end
            if (go) begin
                m_fe = 0; m_fl = 1;
                if (tgt >= LIMIT) begin
                    m_fault = 1; m_halt = 1;
                end else begin
                    if (is_irq) begin m_epc = m_pc; m_ack = 1; m_act = 1; end
                    if (is_eret) m_act = 0;
                    m_pc = tgt; m_halt = 0;
                end
            end else if (m_halt) begin
                m_fl = 0;
            end else if (m_fl) begin
                m_fl = 0; m_fe = !stall_i;
            end else if (halt_i) begin
                m_halt = 1; m_fe = 0;
            end else if (stall_i) begin
                m_fe = 0;
            end else if (!m_fe) begin
                m_fe = 1;
            end else begin
                m_pc = (m_pc == LIMIT - 1) ? 0 : m_pc + 1;
            end
        end
    end

    function automatic int m_state();
        if (m_idle) return 0;
        if (m_halt) return 4;
        if (m_fl) return 3;
        return m_fe ? 1 : 2;
    endfunction

    bit cmp_en = 0;
    always @(negedge clock_i) begin
        if (cmp_en) begin
            chk("pc", 32'(pc_o), 32'(m_pc));
            chk("fetch_enable", 32'(fetch_enable_o), 32'(m_fe));
            chk("flushBack", 32'(flushBack_o), 32'(m_fl));
            chk("irq_ack", 32'(irq_ack_o), 32'(m_ack));
            chk("irq_active", 32'(irq_active_o), 32'(m_act));
            chk("epc", 32'(epc_o), 32'(m_epc));
            chk("fault", 32'(fault_o), 32'(m_fault));
            chk("state", 32'(state_o), 32'(m_state()));
        end
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic look(input string nm, input int pc, input bit fe, input bit fl, input int st);
        chk({nm, ".pc"}, 32'(pc_o), 32'(pc));
        chk({nm, ".fe"}, 32'(fetch_enable_o), 32'(fe));
        chk({nm, ".flush"}, 32'(flushBack_o), 32'(fl));
        chk({nm, ".state"}, 32'(state_o), 32'(st));
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b1;
    endtask

    initial begin
        #1 reset_i = 1'b0;
        #2;
        look("reset", 1, 0, 0, 0);
        chk("reset.epc", 32'(epc_o), 0);
        chk("reset.fault", 32'(fault_o), 0);
        cmp_en = 1;
        tick();
        reset_i = 1'b1;
        tick();
        look("idle_hold", 1, 0, 0, 0);

        start_i = 1'b1; tick(); start_i = 1'b0;
        look("start", 1, 1, 0, 1);
        tick();
        look("seq2", 2, 1, 0, 1);
        repeat (97) tick();
        look("pc99", 99, 1, 0, 1);
        tick();
        look("wrap0", 0, 1, 0, 1);
        repeat (5) tick();
        look("pc5", 5, 1, 0, 1);

        stall_i = 1'b1;
        tick(); look("stall1", 5, 0, 0, 2);
        tick(); look("stall2", 5, 0, 0, 2);
        tick(); look("stall3", 5, 0, 0, 2);
        stall_i = 1'b0;
        tick(); look("unstall", 5, 1, 0, 1);
        tick(); look("after_stall", 6, 1, 0, 1);

        repeat (6) tick();
        look("pc12", 12, 1, 0, 1);
        branch_taken_i = 1'b1; branch_target_i = 16'd14;
        tick(); branch_taken_i = 1'b0;
        look("br_flush", 14, 0, 1, 3);
        tick(); look("br_tgt", 14, 1, 0, 1);
        tick(); look("br_next", 15, 1, 0, 1);

        branch_taken_i = 1'b1; branch_target_i = 16'd5;
        tick(); branch_taken_i = 1'b0;
        repeat (3) tick();
        look("pc7", 7, 1, 0, 1);
        irq_i = 1'b1;
        tick();
        look("irq_flush", 16'h40, 0, 1, 3);
        chk("irq.ack", 32'(irq_ack_o), 1);
        chk("irq.epc", 32'(epc_o), 7);
        chk("irq.active", 32'(irq_active_o), 1);
        tick(); look("irq_vec", 16'h40, 1, 0, 1);
        chk("irq.ack_drop", 32'(irq_ack_o), 0);
        tick(); look("irq_masked", 16'h41, 1, 0, 1);
        irq_i = 1'b0; eret_i = 1'b1;
        tick(); eret_i = 1'b0;
        look("eret_flush", 7, 0, 1, 3);
        chk("eret.active", 32'(irq_active_o), 0);
        tick(); look("eret_tgt", 7, 1, 0, 1);
        tick(); look("eret_next", 8, 1, 0, 1);

        branch_taken_i = 1'b1; branch_target_i = 16'd20; irq_i = 1'b1;
        tick(); branch_taken_i = 1'b0;
        look("both_br", 20, 0, 1, 3);
        chk("both.ack0", 32'(irq_ack_o), 0);
        tick(); irq_i = 1'b0;
        look("both_irq", 16'h40, 0, 1, 3);
        chk("both.epc", 32'(epc_o), 20);
        chk("both.ack", 32'(irq_ack_o), 1);
        tick();
        eret_i = 1'b1; tick(); eret_i = 1'b0;
        tick(); look("back20", 20, 1, 0, 1);

        halt_i = 1'b1; tick(); halt_i = 1'b0;
        look("halt", 20, 0, 0, 4);
        tick(); look("halt_hold", 20, 0, 0, 4);
        irq_i = 1'b1; tick(); irq_i = 1'b0;
        look("halt_irq", 16'h40, 0, 1, 3);
        chk("halt_irq.epc", 32'(epc_o), 20);
        tick();
        eret_i = 1'b1; tick(); eret_i = 1'b0;
        tick(); look("halt_ret", 20, 1, 0, 1);

        branch_taken_i = 1'b1; branch_target_i = 16'd150;
        tick(); branch_taken_i = 1'b0;
        look("fault", 20, 0, 1, 4);
        chk("fault.flag", 32'(fault_o), 1);
        tick(); look("fault_hold", 20, 0, 0, 4);
        chk("fault.sticky", 32'(fault_o), 1);

        do_reset();
        chk("fault.cleared", 32'(fault_o), 0);
        start_i = 1'b1; tick(); start_i = 1'b0;
        irq_i = 1'b1; tick(); irq_i = 1'b0;
        look("pre_async", 16'h40, 0, 1, 3);
        chk("pre_async.epc", 32'(epc_o), 1);
        #2 reset_i = 1'b0;
        #1;
        look("async_rst", 1, 0, 0, 0);
        chk("async.ack", 32'(irq_ack_o), 0);
        chk("async.active", 32'(irq_active_o), 0);
        chk("async.epc", 32'(epc_o), 0);
        tick();
        reset_i = 1'b1;
        tick();
        look("post_async", 1, 0, 0, 0);

        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the program counter and sequences the Fetch stage. Each cycle it issues one bundle address (one 60-bit bundle, two 30-bit instructions) with a fetch enable. It arbitrates between sources of the next PC: taken branches, interrupt entry/return, stall hold, halt and sequential increment. On every redirect it emits a one-cycle flushBack pulse that squashes wrong-path bundles in Fetch and the downstream stages.

Parameters:
RESET_PC, 16'h0001, PC loaded at reset.
IRQ_VECTOR, 16'h0040, handler entry address.
PC_LIMIT, 100, number of i-cache bundles; legal PCs are 0..PC_LIMIT-1.

Ports:
clock_i  in  1  clock; all state changes on its rising edge.
reset_i  in  1  asynchronous, active-low reset.
start_i  in  1  leave IDLE and begin fetching.
stall_i  in  1  hold request from the dependency unit.
branch_taken_i  in  1  resolved taken branch (one-cycle pulse).
branch_target_i  in  16  absolute bundle address of the branch target.
irq_i  in  1  level-sensitive interrupt request.
eret_i  in  1  return-from-interrupt (one-cycle pulse).
halt_i  in  1  halt request.
pc_o  out  16  bundle address driven to Fetch.
fetch_enable_o  out  1  1 when pc_o is a valid fetch this cycle.
flushBack_o  out  1  one-cycle squash pulse.
irq_ack_o  out  1  one-cycle pulse on interrupt acceptance.
irq_active_o  out  1  handler running; further interrupts masked.
epc_o  out  16  saved return PC.
fault_o  out  1  sticky flag: out-of-range redirect target.
state_o  out  3  encoded FSM state, for debug.

Behaviour:
- Reset (asserted, async): pc_o=RESET_PC, fetch_enable_o=0, flushBack_o=0, irq_ack_o=0, irq_active_o=0, epc_o=0, fault_o=0, state=IDLE. Assertion mid-operation takes effect immediately, with no partial redirect. Release is sampled at the next clock_i edge.
- States and encodings: IDLE=0, RUN=1, STALL=2, FLUSH=3, HALT=4.
- IDLE: all outputs hold. start_i -> RUN with fetch_enable_o=1 at pc_o=RESET_PC on the next cycle.
- RUN: fetch_enable_o=1 and pc_o advances by 1 per cycle. PC_LIMIT-1 wraps to 0.
- Per-edge priority in RUN/STALL, highest first: branch_taken_i, eret_i (only when irq_active_o=1, otherwise ignored), irq_i (only when irq_active_o=0), halt_i, stall_i, sequential.
- Redirect (branch, eret or irq accepted at edge N):
  - Edge N+1: pc_o=target, flushBack_o=1, fetch_enable_o=0, state=FLUSH.
  - Edge N+2: flushBack_o=0, fetch_enable_o=1, pc_o=target; state=RUN, or STALL if stall_i=1.
  - Sequential increment resumes at N+3.
  - Targets: branch uses branch_target_i; irq uses IRQ_VECTOR; eret uses epc_o.
- irq acceptance: epc_o <= pc_o value at edge N. The bundle issued that cycle is squashed, so it is re-fetched on return. irq_ack_o pulses at N+1 and irq_active_o is set. eret clears irq_active_o at N+1.
- Stall: pc_o holds, fetch_enable_o=0, state=STALL. stall_i low -> RUN, re-presenting the same pc_o with fetch_enable_o=1, so the held bundle is fetched exactly once. A redirect during STALL is accepted and overrides the stall.
- Events during FLUSH: branch or irq re-redirects with another FLUSH cycle, using the same priority. halt_i is deferred until RUN.
- Halt: fetch_enable_o=0, pc_o holds, state=HALT. Only an irq (if unmasked) or reset leaves HALT. The irq path saves epc_o=pc_o.
- Out-of-range target (>= PC_LIMIT): fault_o set and sticky until reset, flushBack_o pulses, state -> HALT, pc_o unchanged.
- Simultaneous branch_taken_i and irq_i: branch wins, and irq is accepted on the next eligible edge because it is level-sensitive.
- All arithmetic is 16-bit unsigned. Increment uses the wrap rule above, never modulo 2^16.

Test Plan:
- Reset release, start_i=1 -> pc_o sequence 1,2,3,… with fetch_enable_o=1; at PC_LIMIT-1 (=99) the next pc_o is 0.
- stall_i high for 3 cycles while pc_o=5 -> pc_o stays 5 with fetch_enable_o=0 for 3 cycles, then 5 is issued once, then 6.
- branch_taken_i pulse with target 14 while pc_o=12 -> next cycle pc_o=14, flushBack_o=1, fetch_enable_o=0; then 14 enabled, then 15.
- irq_i while pc_o=7 -> epc_o=7, irq_ack_o pulse, pc_o=0x40 after one flush cycle; a second irq_i is ignored; eret_i -> pc_o=7, irq_active_o=0.
- Simultaneous branch (target 20) and irq while irq_active_o=0 -> redirect to 20 first; the following edge accepts the irq with epc_o=20.
- branch_target_i=150 -> fault_o=1, state_o=4, fetch_enable_o stays 0. Async reset asserted mid-FLUSH -> all outputs return to reset values without waiting for a clock edge.
